// File: rtl/picosoc_arb_pkg.sv
// Shared types and defaults for the PicoSoC two-master bus arbiter.
package picosoc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  typedef logic grant_idx_t;

  localparam int unsigned WDOG_W             = 16;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 255;
  localparam logic [31:0] DEF_TIMEOUT_RDATA  = 32'h0000_0000;

endpackage

// File: rtl/picosoc_bus_watchdog.sv
// Saturating granted-cycle counter; flags the cycle in which the transaction must be cut off.
module picosoc_bus_watchdog
  import picosoc_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic resetn,
  input  logic run,
  input  logic clear,
  output logic expire
);

  localparam logic [WDOG_W-1:0] LP_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WDOG_W-1:0] LP_ONE  = WDOG_W'(1);

  logic [WDOG_W-1:0] r_count;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (run && (r_count != '1)) begin
      r_count <= r_count + LP_ONE;
    end
  end

  assign expire = run && (r_count == LP_LAST);

endmodule

// File: rtl/picosoc_bus_arbiter.sv
// Round-robin arbiter sharing the PicoSoC native memory bus between two masters,
// holding each grant until completion and force-completing unanswered transactions.
module picosoc_bus_arbiter
  import picosoc_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [31:0] TIMEOUT_RDATA  = DEF_TIMEOUT_RDATA
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  output logic        timeout_err
);

  arb_state_t r_state, w_state_nxt;
  grant_idx_t r_last_grant, w_last_grant_nxt;
  grant_idx_t w_sel;
  logic       w_granted, w_req, w_run, w_clear, w_expire, w_done;

  assign w_granted = (r_state != IDLE);
  assign w_sel     = (r_state == GNT1);
  assign w_req     = w_sel ? m1_valid : m0_valid;
  assign w_run     = w_granted && w_req && !s_ready;
  // Any exit from a grant (completion, expiry or a dropped request) rearms the watchdog.
  assign w_clear   = !w_granted || !w_req || s_ready || w_expire;

  picosoc_bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk   (clk),
    .resetn(resetn),
    .run   (w_run),
    .clear (w_clear),
    .expire(w_expire)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_done           = 1'b0;
    s_valid          = 1'b0;
    s_addr           = '0;
    s_wdata          = '0;
    s_wstrb          = '0;
    m0_ready         = 1'b0;
    m1_ready         = 1'b0;
    m0_rdata         = '0;
    m1_rdata         = '0;
    timeout_err      = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (m0_valid && m1_valid) begin
          w_state_nxt = r_last_grant ? GNT0 : GNT1;
        end else if (m0_valid) begin
          w_state_nxt = GNT0;
        end else if (m1_valid) begin
          w_state_nxt = GNT1;
        end
      end
      GNT0, GNT1: begin
        s_valid     = w_req && !w_expire;
        s_addr      = w_sel ? m1_addr  : m0_addr;
        s_wdata     = w_sel ? m1_wdata : m0_wdata;
        s_wstrb     = w_sel ? m1_wstrb : m0_wstrb;
        w_done      = w_req && (s_ready || w_expire);
        timeout_err = w_expire;
        if (w_sel) begin
          m1_ready = w_done;
          m1_rdata = w_expire ? TIMEOUT_RDATA : s_rdata;
        end else begin
          m0_ready = w_done;
          m0_rdata = w_expire ? TIMEOUT_RDATA : s_rdata;
        end
        // A master that abandons its request loses the grant without affecting fairness.
        if (!w_req) begin
          w_state_nxt = IDLE;
        end else if (w_done) begin
          w_state_nxt      = IDLE;
          w_last_grant_nxt = w_sel;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_picosoc_bus_arbiter.sv
// Directed bench for picosoc_bus_arbiter: stimulus pushes expected master responses,
// a negedge monitor pops and compares them whenever a completion appears.
module tb_picosoc_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        m0_valid = 1'b0, m1_valid = 1'b0;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic        s_ready = 1'b0;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic [31:0] s_rdata = '0;
  logic        timeout_err;

  always #5 clk = ~clk;

  picosoc_bus_arbiter #(
    .TIMEOUT_CYCLES(4),
    .TIMEOUT_RDATA (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .m0_valid   (m0_valid),
    .m0_ready   (m0_ready),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_wstrb   (m0_wstrb),
    .m0_rdata   (m0_rdata),
    .m1_valid   (m1_valid),
    .m1_ready   (m1_ready),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_wstrb   (m1_wstrb),
    .m1_rdata   (m1_rdata),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_addr     (s_addr),
    .s_wdata    (s_wdata),
    .s_wstrb    (s_wstrb),
    .s_rdata    (s_rdata),
    .timeout_err(timeout_err)
  );

  typedef struct packed {
    logic [1:0]  rdy;   // {m1_ready, m0_ready}
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic        terr;
  } resp_t;

  resp_t        exp_q[$];
  resp_t        mon_act;
  int           n_vec = 0;
  int           n_miss = 0;
  int           sv_cycles = 0;
  logic [135:0] all_outs;

  assign all_outs = {s_valid, s_addr, s_wdata, s_wstrb, m0_ready, m1_ready,
                     m0_rdata, m1_rdata, timeout_err};

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic resp_t mk(input int m, input logic [31:0] rd, input logic te);
    resp_t r;
    r.rdy  = (m == 0) ? 2'b01 : 2'b10;
    r.rd0  = (m == 0) ? rd : 32'h0;
    r.rd1  = (m == 0) ? 32'h0 : rd;
    r.terr = te;
    return r;
  endfunction

  task automatic push(input int m, input logic [31:0] rd, input logic te);
    exp_q.push_back(mk(m, rd, te));
  endtask

  // Returns at the start of the first granted cycle.
  task automatic wait_sv(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = s_valid;
    end
    if (!seen) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s: s_valid got 0 for 20 cycles, required 1", name);
    end
  endtask

  // Slave answers 'lat' cycles after the current granted cycle; returns in the following cycle.
  task automatic complete(input int lat, input logic [31:0] rd);
    repeat (lat) begin
      @(posedge clk);
      #1;
    end
    s_ready = 1'b1;
    s_rdata = rd;
    @(posedge clk);
    #1;
    s_ready = 1'b0;
    s_rdata = '0;
  endtask

  always @(negedge clk) begin
    if (s_valid) sv_cycles++;
    if (m0_ready || m1_ready || timeout_err) begin
      mon_act = {m1_ready, m0_ready, m0_rdata, m1_rdata, timeout_err};
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_response: got %0h, required no response", mon_act);
      end else begin
        check("response", mon_act, exp_q.pop_front());
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    check("reset_outputs", all_outs, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // Simultaneous requests from reset: grants alternate 0,1,0,1 with an idle bubble.
    m0_addr  = 32'h0000_0100;
    m1_addr  = 32'h0000_0200;
    m0_valid = 1'b1;
    m1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(i % 2, 32'h1000_0000 + i, 1'b0);
      wait_sv("alt_grant");
      check("alt_grant_addr", s_addr, (i % 2) ? 32'h0000_0200 : 32'h0000_0100);
      complete(1, 32'h1000_0000 + i);
      check("alt_idle_bubble", s_valid, 1'b0);
    end
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    @(posedge clk);
    #1;

    // m0 read, slave ready after 2 cycles.
    sv_cycles = 0;
    m0_addr   = 32'h0000_0010;
    m0_wstrb  = 4'b0000;
    m0_valid  = 1'b1;
    push(0, 32'h1234_5678, 1'b0);
    wait_sv("m0_read");
    complete(2, 32'h1234_5678);
    m0_valid = 1'b0;
    check("m0_read_s_valid_cycles", sv_cycles, 3);

    // m1 write: strobes and bus muxed only while granted.
    m1_addr  = 32'h0300_0000;
    m1_wdata = 32'hCAFE_F00D;
    m1_wstrb = 4'b0011;
    m1_valid = 1'b1;
    push(1, 32'h0, 1'b0);
    wait_sv("m1_write");
    check("m1_write_bus", {s_addr, s_wdata, s_wstrb}, {32'h0300_0000, 32'hCAFE_F00D, 4'b0011});
    complete(0, 32'h0);
    check("idle_wstrb_zero", {s_valid, s_wstrb}, 5'b0);
    m1_valid = 1'b0;
    m1_wstrb = 4'b0000;
    @(posedge clk);
    #1;

    // Watchdog expiry on m0 with m1 waiting; slave drives garbage rdata.
    m0_addr  = 32'h0000_0020;
    m0_valid = 1'b1;
    wait_sv("timeout_m0");
    m1_addr  = 32'h0000_0400;
    m1_valid = 1'b1;
    s_rdata  = 32'hDEAD_BEEF;
    push(0, 32'h0, 1'b1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("expiry_cycle", {s_valid, m0_ready, timeout_err, m0_rdata}, {1'b0, 1'b1, 1'b1, 32'h0});
    @(posedge clk);
    #1;
    m0_valid = 1'b0;
    s_rdata  = 32'h0;
    push(1, 32'h55AA_0001, 1'b0);
    wait_sv("pending_m1");
    check("pending_m1_addr", s_addr, 32'h0000_0400);
    complete(0, 32'h55AA_0001);
    m1_valid = 1'b0;
    @(posedge clk);
    #1;

    // s_ready in the expiry cycle wins: normal completion, no error.
    m0_addr  = 32'h0000_0030;
    m0_valid = 1'b1;
    push(0, 32'hA5A5_5A5A, 1'b0);
    wait_sv("ready_at_expiry");
    complete(3, 32'hA5A5_5A5A);
    m0_valid = 1'b0;
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a GNT1 transaction.
    m1_addr  = 32'h0000_0500;
    m1_valid = 1'b1;
    wait_sv("reset_mid_gnt1");
    resetn = 1'b0;
    #1;
    check("async_reset_outputs", all_outs, 0);
    m0_addr  = 32'h0000_0600;
    m0_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    push(0, 32'h0000_0066, 1'b0);
    wait_sv("post_reset_tie");
    check("post_reset_m0_wins", s_addr, 32'h0000_0600);
    complete(0, 32'h0000_0066);
    m0_valid = 1'b0;
    push(1, 32'h0000_0077, 1'b0);
    wait_sv("post_reset_m1");
    check("post_reset_m1_addr", s_addr, 32'h0000_0500);
    complete(0, 32'h0000_0077);
    m1_valid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/picosoc_bus_arbiter.md
Name: picosoc_bus_arbiter

Overview:
Two-master arbiter that shares the single PicoSoC native memory bus (valid/ready/addr/wdata/wstrb/rdata) between the CPU and a second master such as a DMA or debug port. It sits between the masters and the existing address decode and slave logic. Arbitration is round-robin, and a grant is held until the transaction completes. A watchdog terminates any transaction that the slave never acknowledges.

Parameters:
TIMEOUT_CYCLES, 255 – number of granted cycles without s_ready before forced completion; range 1..65535.
TIMEOUT_RDATA, 32'h0000_0000 – read data returned to the master on a timed-out transaction.

Ports:
clk  in  1  system clock, rising edge.
resetn  in  1  asynchronous active-low reset.
m0_valid  in  1  master 0 (CPU) request.
m0_ready  out  1  master 0 transaction complete.
m0_addr  in  32  master 0 address.
m0_wdata  in  32  master 0 write data.
m0_wstrb  in  4  master 0 byte strobes; 0 means read.
m0_rdata  out  32  master 0 read data.
m1_valid, m1_ready, m1_addr, m1_wdata, m1_wstrb, m1_rdata – same directions and widths as m0_*, for master 1.
s_valid  out  1  request to the slave/decode side.
s_ready  in  1  slave completion.
s_addr  out  32  muxed address.
s_wdata  out  32  muxed write data.
s_wstrb  out  4  muxed strobes.
s_rdata  in  32  slave read data.
timeout_err  out  1  one-cycle pulse when a transaction is force-completed.

Behaviour:
- Reset values (resetn low, asynchronous):
  - state=IDLE, last_grant=1 (master 0 wins the first tie), wdog counter=0, timeout_err=0.
  - All outputs 0: s_valid, s_addr, s_wdata, s_wstrb, m*_ready, m*_rdata.
- States:
  - IDLE: no grant. s_* outputs all 0; s_wstrb must be 0.
  - GNT0 / GNT1: s_valid/s_addr/s_wdata/s_wstrb = mX_* (combinational).
- IDLE transitions, evaluated at each clock edge:
  - only m0_valid → GNT0; only m1_valid → GNT1.
  - both valid → grant the master that is NOT last_grant.
  - neither → stay IDLE.
- Arbitration latency: valid seen at edge N; s_valid first asserts in the cycle after edge N. Minimum one IDLE bubble between consecutive transactions.
- In GNTx, normal completion:
  - mx_ready = s_ready, mx_rdata = s_rdata; the ungranted master sees ready=0, rdata=0.
  - On s_ready=1 at an edge: last_grant←x, wdog←0, next state IDLE.
  - The ungranted master's valid is ignored and held pending; no starvation, since it wins the next tie.
- Watchdog:
  - wdog increments every GNTx cycle without s_ready.
  - In the cycle wdog==TIMEOUT_CYCLES-1 with s_ready=0, all of the following happen in that same cycle: s_valid forced 0, mx_ready=1, mx_rdata=TIMEOUT_RDATA, timeout_err=1.
  - At the next edge: last_grant←x, state→IDLE.
  - s_ready arriving in that same cycle takes priority: normal completion, no error.
- Protocol violation: master drops mx_valid while in GNTx → next edge to IDLE, no ready issued, last_grant unchanged, wdog←0.
- Reset mid-transaction: immediate return to IDLE with all outputs 0. No completion is reported to either master.
- Counter width: 16 bits. The wdog counter saturates and must never wrap.

Decomposition:
- Shared package picosoc_arb_pkg: state enum {IDLE, GNT0, GNT1}, grant-index type, default TIMEOUT constants.
- One sub-module is natural: picosoc_bus_watchdog (counter plus expiry compare; inputs clk, resetn, run, clear; output expire).
- Muxing and the FSM stay in the top module.

Test Plan:
- m0 read 0x0000_0010, slave ready after 2 cycles with rdata 0x1234_5678 → m0_ready pulses once, m0_rdata=0x1234_5678, s_valid high for exactly 3 cycles, m1_ready stays 0.
- m0 and m1 assert valid on the same cycle from reset → m0 served first, then after one IDLE cycle m1; with both held continuously, grants alternate 0,1,0,1.
- m1 write addr 0x0300_0000, wdata 0xCAFE_F00D, wstrb 4'b0011 → s_wstrb=4'b0011 and s_addr/s_wdata match while GNT1; s_wstrb=0 in IDLE.
- TIMEOUT_CYCLES=4, slave never ready, m0 read → m0_ready and timeout_err high in the 4th granted cycle, m0_rdata=0, s_valid low in that cycle; then pending m1 is granted.
- s_ready arrives exactly in the expiry cycle → normal completion with s_rdata, timeout_err stays 0.
- resetn pulsed low mid-GNT1 → all outputs 0 asynchronously; after release, m0 wins the first tie.
